// File: rtl/udp_rx_ddr_wr_ctrl.sv
// Drains the UDP RX show-ahead FIFO into a DDR ring buffer via FDMA write bursts.
// Full bursts fire on fill level; partial bursts flush after an idle timeout.
module udp_rx_ddr_wr_ctrl #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [31:0] BUF_BYTES = 32'h0010_0000,
   parameter int unsigned BURST_LEN = 256,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [11:0] fifo_rdusedw,
   input  logic        fifo_empty,
   input  logic [31:0] fifo_dout,
   output logic        fifo_re,
   output logic [31:0] fdma_waddr,
   output logic [15:0] fdma_wsize,
   output logic        fdma_wareq,
   input  logic        fdma_wbusy,
   input  logic        fdma_wvalid,
   output logic [31:0] fdma_wdata,
   output logic [31:0] wr_ptr,
   output logic        burst_done,
   output logic        err_underflow,
   input  logic        err_clr
);

   localparam logic [31:0] RING_END = ADDR_BASE + BUF_BYTES;
   localparam logic [31:0] BURST_W  = 32'(BURST_LEN);
   localparam logic [31:0] TMO_MAX  = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] wr_ptr_q, wr_ptr_d;
   logic [31:0] waddr_q, waddr_d;
   logic [15:0] wsize_q, wsize_d;
   logic        wareq_q, wareq_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] tcnt_q, tcnt_d;
   logic [15:0] beat_q, beat_d;

   logic [31:0] usedw_s;
   logic [31:0] room_s;
   logic [31:0] cap_s;
   logic [31:0] len_s;
   logic        full_s;
   logic        qual_s;
   logic        trig_s;
   logic        beat_s;
   logic [31:0] ptr_sum_s;
   logic [31:0] ptr_next_s;

   assign usedw_s = {20'd0, fifo_rdusedw};
   assign room_s  = (RING_END - wr_ptr_q) >> 2;
   assign cap_s   = (usedw_s > BURST_W) ? BURST_W : usedw_s;
   assign len_s   = (cap_s > room_s) ? room_s : cap_s;
   assign full_s  = (usedw_s >= BURST_W);
   assign qual_s  = !fifo_empty && !full_s;
   // The burst_done cycle is held off so that the gap between bursts is at least one IDLE cycle;
   // a zero-length burst is never requested even if the level lags the empty flag.
   assign trig_s  = en && !done_q && (usedw_s != 32'd0) &&
                    (full_s || ((tcnt_q == TMO_MAX) && !fifo_empty));

   assign beat_s     = (state_q == S_DATA) && fdma_wvalid;
   assign fifo_re    = beat_s;
   assign fdma_wdata = fifo_dout;

   assign ptr_sum_s  = wr_ptr_q + {14'd0, wsize_q, 2'b00};
   assign ptr_next_s = (ptr_sum_s == RING_END) ? ADDR_BASE : ptr_sum_s;

   assign fdma_waddr    = waddr_q;
   assign fdma_wsize    = wsize_q;
   assign fdma_wareq    = wareq_q;
   assign wr_ptr        = wr_ptr_q;
   assign burst_done    = done_q;
   assign err_underflow = err_q;

   // Next-state and registered-output logic for the burst FSM.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      waddr_d  = waddr_q;
      wsize_d  = wsize_q;
      wareq_d  = wareq_q;
      done_d   = 1'b0;
      tcnt_d   = 32'd0;
      beat_d   = beat_q;

      case (state_q)
         S_IDLE: begin
            if (trig_s) begin
               state_d = S_REQ;
               waddr_d = wr_ptr_q;
               wsize_d = len_s[15:0];
               wareq_d = 1'b1;
            end else if (qual_s) begin
               tcnt_d = (tcnt_q == TMO_MAX) ? tcnt_q : tcnt_q + 32'd1;
            end else begin
               tcnt_d = 32'd0;
            end
         end
         S_REQ: begin
            if (fdma_wbusy) begin
               state_d = S_DATA;
               wareq_d = 1'b0;
            end else begin
               state_d = S_REQ;
            end
         end
         S_DATA: begin
            if (beat_s) begin
               if ((beat_q + 16'd1) == wsize_q) begin
                  state_d = S_DONE;
                  beat_d  = 16'd0;
               end else begin
                  beat_d  = beat_q + 16'd1;
               end
            end else begin
               beat_d = beat_q;
            end
         end
         S_DONE: begin
            if (!fdma_wbusy) begin
               state_d  = S_IDLE;
               wr_ptr_d = ptr_next_s;
               done_d   = 1'b1;
            end else begin
               state_d  = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            wareq_d = 1'b0;
            beat_d  = 16'd0;
         end
      endcase
   end

   // Sticky underflow flag; a new underflow beat takes priority over the clear.
   always_comb begin
      if (beat_s && fifo_empty) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= ADDR_BASE;
         waddr_q  <= ADDR_BASE;
         wsize_q  <= 16'd0;
         wareq_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         tcnt_q   <= 32'd0;
         beat_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         waddr_q  <= waddr_d;
         wsize_q  <= wsize_d;
         wareq_q  <= wareq_d;
         done_q   <= done_d;
         err_q    <= err_d;
         tcnt_q   <= tcnt_d;
         beat_q   <= beat_d;
      end
   end

endmodule
